// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Operation context latched at accept time and used by FIXUP.
    typedef struct packed {
        op_e  op;
        logic sign_a;
        logic sign_b;
    } ctx_t;

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply bit or restoring divide bit.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] opnd_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] cand;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        cand = {hi_i, lo_i[XLEN-1]};
        diff = cand - {1'b0, opnd_i};
        if (is_div_i) begin
            // diff[XLEN] is the borrow: partial remainder smaller than divisor
            hi_o = diff[XLEN] ? cand[XLEN-1:0] : diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: UNROLL result bits per CALC cycle,
// busy while computing, one-cycle done pulse with a registered result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int unsigned N     = XLEN / UNROLL;
    localparam int unsigned CNT_W = $clog2(N + 1);

    state_e            state_q, state_d;
    ctx_t              ctx_q, ctx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    op_e               op_in;
    logic              sa_in, sb_in;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic              calc_div;

    // Request decode: per-op signedness, magnitudes and the single-cycle special cases
    always_comb begin
        op_in    = op_e'(bus.funct3);
        sa_in    = a_signed(op_in) & bus.a[XLEN-1];
        sb_in    = b_signed(op_in) & bus.b[XLEN-1];
        abs_a    = sa_in ? -bus.a : bus.a;
        abs_b    = sb_in ? -bus.b : bus.b;
        div_zero = is_div(op_in) && (bus.b == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM)
                   && (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.b == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : bus.a;
        end else if (div_ovf) begin
            fast_res = (op_in == OP_DIV) ? bus.a : '0;
        end
    end

    assign calc_div = is_div(ctx_q.op);

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;
        if (g == 0) begin : g_first
            assign hi_in = hi_q;
            assign lo_in = lo_q;
        end else begin : g_next
            assign hi_in = g_step[g-1].hi_out;
            assign lo_in = g_step[g-1].lo_out;
        end
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div_i (calc_div),
            .opnd_i   (opnd_q),
            .hi_i     (hi_in),
            .lo_i     (lo_in),
            .hi_o     (hi_out),
            .lo_o     (lo_out)
        );
    end

    assign step_hi = g_step[UNROLL-1].hi_out;
    assign step_lo = g_step[UNROLL-1].lo_out;

    // Sign correction and result select once iteration has finished
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (ctx_q.sign_a ^ ctx_q.sign_b) ? -prod : prod;
        q_fix    = (ctx_q.sign_a ^ ctx_q.sign_b) ? -lo_q : lo_q;
        r_fix    = ctx_q.sign_a ? -hi_q : hi_q;
        case (ctx_q.op)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = q_fix;
            default:                      fix_res = r_fix;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.flush) begin
                    ctx_d.op     = op_in;
                    ctx_d.sign_a = sa_in;
                    ctx_d.sign_b = sb_in;
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CNT_W'(N);
                        hi_d    = '0;
                        lo_d    = is_div(op_in) ? abs_a : abs_b;
                        opnd_d  = is_div(op_in) ? abs_b : abs_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctx_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctx_q    <= ctx_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: an UNROLL=1 and an UNROLL=4 instance share clk/reset.
module tb_muldiv_unit;
    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] q1[$];
    logic [31:0] q4[$];
    logic [31:0] last1 = '0;

    muldiv_if #(.XLEN(32)) bus1 ();
    muldiv_if #(.XLEN(32)) bus4 ();

    muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut1 (.clk(clk), .reset(rst), .bus(bus1));
    muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (.clk(clk), .reset(rst), .bus(bus4));

    // Reference behaviour of the M-extension ops for XLEN=32
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sub, p;
        logic [63:0] ua, ub, up;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = ub;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F_MUL:    begin up = ua * ub; return up[31:0]; end
            F_MULH:   begin p = sa * sb; return p[63:32]; end
            F_MULHSU: begin p = sa * sub; return p[63:32]; end
            F_MULHU:  begin up = ua * ub; return up[63:32]; end
            F_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic busy_of(input bit u4);
        return u4 ? bus4.busy : bus1.busy;
    endfunction

    function automatic logic done_of(input bit u4);
        return u4 ? bus4.done : bus1.done;
    endfunction

    task automatic drive(input bit u4, input logic st, input logic fl,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (u4) begin
            bus4.start = st; bus4.flush = fl; bus4.funct3 = f; bus4.a = a; bus4.b = b;
        end else begin
            bus1.start = st; bus1.flush = fl; bus1.funct3 = f; bus1.a = a; bus1.b = b;
        end
    endtask

    // Scoreboard: every done pulse pops and compares one expected result
    always @(negedge clk) begin
        if (bus1.done) begin
            total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL u1_unexpected_done: result=%h expected no done", bus1.result);
            end else begin
                logic [31:0] e1;
                e1 = q1.pop_front();
                if (bus1.result !== e1) begin
                    bad++; $display("FAIL u1_result: got %h expected %h", bus1.result, e1);
                end
            end
        end
        if (bus4.done) begin
            total++;
            if (q4.size() == 0) begin
                bad++; $display("FAIL u4_unexpected_done: result=%h expected no done", bus4.result);
            end else begin
                logic [31:0] e4;
                e4 = q4.pop_front();
                if (bus4.result !== e4) begin
                    bad++; $display("FAIL u4_result: got %h expected %h", bus4.result, e4);
                end
            end
        end
    end

    // Issue one op, queue its expected result, check latency and busy-cycle count
    task automatic run_op(input bit u4, input bit b2b, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int exp_busy, input string name);
        int lat, bcnt;
        bit seen;
        if (!b2b) @(negedge clk);
        drive(u4, 1'b1, 1'b0, f, a, b);
        if (u4) q4.push_back(exp);
        else begin q1.push_back(exp); last1 = exp; end
        @(posedge clk); #1;
        drive(u4, 1'b0, 1'b0, f, a, b);
        lat = 0; bcnt = 0; seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (busy_of(u4)) bcnt++;
            if (done_of(u4)) begin seen = 1'b1; lat = i; end
        end
        total++;
        if (lat !== exp_lat) begin
            bad++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        total++;
        if (bcnt !== exp_busy) begin
            bad++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcnt, exp_busy);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 3'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 3'b0, '0, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
        total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL reset_done1: got %b expected 0", bus1.done); end
        total++; if (bus1.result !== 32'h0) begin bad++; $display("FAIL reset_result1: got %h expected 0", bus1.result); end
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy4: got %b expected 0", bus4.busy); end
        total++; if (bus4.result !== 32'h0) begin bad++; $display("FAIL reset_result4: got %h expected 0", bus4.result); end
        rst = 1'b1;
    endtask

    task automatic test_mul();
        run_op(1'b0, 1'b0, F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 33, "mul");
        run_op(1'b0, 1'b0, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 33, "mulhu");
        run_op(1'b0, 1'b0, F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33, "mulhsu");
        run_op(1'b0, 1'b0, F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 33, "mulh");
    endtask

    task automatic test_div();
        run_op(1'b0, 1'b0, F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33, "div_neg");
        run_op(1'b0, 1'b0, F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33, "rem_neg");
        run_op(1'b0, 1'b0, F_DIVU, 32'd100,       32'd7, 32'd14,        34, 33, "divu");
        run_op(1'b0, 1'b0, F_REMU, 32'd100,       32'd7, 32'd2,         34, 33, "remu");
    endtask

    task automatic test_fast_path();
        run_op(1'b0, 1'b0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(1'b0, 1'b0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0, "rem_ovf");
        run_op(1'b0, 1'b0, F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, "divu_zero");
        run_op(1'b0, 1'b0, F_REM,  32'd5,         32'd0,         32'd5,         1, 0, "rem_zero");
    endtask

    task automatic test_flush();
        int dcnt, bcnt;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, F_MUL, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F_MUL, 32'd3, 32'd5);
        for (int i = 1; i <= 10; i++) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, F_MUL, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F_MUL, 32'd3, 32'd5);
        @(negedge clk);
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b expected 0", bus1.busy); end
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus1.done) dcnt++; end
        total++; if (dcnt !== 0) begin bad++; $display("FAIL flush_no_done: got %0d expected 0", dcnt); end
        total++; if (bus1.result !== last1) begin bad++; $display("FAIL flush_result_held: got %h expected %h", bus1.result, last1); end

        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, F_DIVU, 32'd9, 32'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F_DIVU, 32'd9, 32'd3);
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.done) dcnt++;
            if (bus1.busy) bcnt++;
        end
        total++; if (dcnt + bcnt !== 0) begin bad++; $display("FAIL start_flush_ignored: got busy=%0d done=%0d expected 0", bcnt, dcnt); end
        total++; if (bus1.result !== last1) begin bad++; $display("FAIL start_flush_result: got %h expected %h", bus1.result, last1); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, F_DIVU, 32'd100, 32'd7);
        q1.push_back(32'd14); last1 = 32'd14;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, F_DIVU, 32'd100, 32'd7);
        lat = 0;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(negedge clk);
            if (bus1.done) lat = i;
            if (i == 5) drive(1'b0, 1'b1, 1'b0, F_MUL, 32'd1, 32'd1);
            else if (i == 6) drive(1'b0, 1'b0, 1'b0, F_MUL, 32'd1, 32'd1);
        end
        total++; if (lat !== 34) begin bad++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
        repeat (5) @(negedge clk);
        total++; if (bus1.result !== 32'd14) begin bad++; $display("FAIL busy_start_result: got %h expected %h", bus1.result, 32'd14); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, F_DIVU, 32'd1000, 32'd10, 32'd100, 10, 9, "u4_divu");
        run_op(1'b1, 1'b1, F_REMU, 32'd1000, 32'd7,  32'd6,   10, 9, "u4_b2b_remu");
        run_op(1'b1, 1'b1, F_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 10, 9, "u4_b2b_mulh");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, e;
        bit fp;
        for (int k = 0; k < 12; k++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            e  = model(f, a, b);
            fp = is_fast(f, a, b);
            if (k[0]) run_op(1'b1, 1'b0, f, a, b, e, fp ? 1 : 10, fp ? 0 : 9,  "rand_u4");
            else      run_op(1'b0, 1'b0, f, a, b, e, fp ? 1 : 34, fp ? 0 : 33, "rand_u1");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F_DIVU, 32'd1000, 32'd10);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, F_DIVU, 32'd1000, 32'd10);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b expected 0", bus4.busy); end
        total++; if (bus4.done !== 1'b0) begin bad++; $display("FAIL async_reset_done: got %b expected 0", bus4.done); end
        total++; if (bus4.result !== 32'h0) begin bad++; $display("FAIL async_reset_result: got %h expected 0", bus4.result); end
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        total++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            bad++; $display("FAIL async_reset_idle: got busy=%b done=%b expected 0 0", bus4.busy, bus4.done);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_flush();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_async_reset();
        total++;
        if (q1.size() + q4.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending expected 0", q1.size() + q4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
